// File: rtl/synth_cmd_pkg.sv
// Shared constants and parser state type for the MIDI-to-synth command path.
package synth_cmd_pkg;

  localparam int          CMD_START_BIT = 15;
  localparam logic [6:0]  STOP_ALL_NOTE = 7'h7F;
  localparam logic [15:0] STOP_ALL_CMD  = 16'h7F00;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;

  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'h78;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'h7B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA1,
    ST_DATA2,
    ST_SYSEX
  } parser_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Small command buffer; extra pointer bit separates full from empty.
module cmd_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic [15:0] push_data,
  input  logic        pop,
  output logic [15:0] pop_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [15:0] mem [FIFO_DEPTH];
  logic        push_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot, so a push while full is still taken.
  assign push_ok  = push && (!full || pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/midi_cmd_decoder.sv
// MIDI byte parser producing one-cycle synth commands, buffered and paced by a gap counter.
module midi_cmd_decoder
  import synth_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  input  logic [3:0]  i_channel,
  input  logic        i_omni,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_overflow
);

  localparam int            GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  parser_state_t state, next_state;
  logic [7:0]    status;
  logic [6:0]    d1;
  logic          status_load;
  logic          d1_load;
  logic          cmd_valid;
  logic [15:0]   cmd;
  logic [3:0]    hi;
  logic          chan_ok;
  logic [GW-1:0] gap_cnt;
  logic          pop;
  logic [15:0]   pop_data;
  logic          full;
  logic          empty;

  assign hi      = status[7:4];
  assign chan_ok = i_omni || (status[3:0] == i_channel);

  always_comb begin
    next_state  = state;
    status_load = 1'b0;
    d1_load     = 1'b0;
    cmd_valid   = 1'b0;
    cmd         = '0;
    if (i_byte_valid && i_byte < 8'hF8) begin
      if (i_byte[7] && i_byte < 8'hF0) begin
        status_load = 1'b1;
        next_state  = ST_DATA1;
      end else if (state == ST_SYSEX) begin
        if (i_byte == 8'hF7) next_state = ST_IDLE;
      end else if (i_byte == 8'hF0) begin
        next_state = ST_SYSEX;
      end else if (i_byte[7]) begin
        next_state = ST_IDLE;
      end else begin
        case (state)
          ST_DATA1: begin
            if (hi == PROG || hi == CHPRESS) begin
              next_state = ST_DATA1;
            end else begin
              d1_load    = 1'b1;
              next_state = ST_DATA2;
            end
          end
          ST_DATA2: begin
            next_state = ST_DATA1;
            if (chan_ok) begin
              if (hi == NOTE_ON && i_byte[6:0] != 7'd0) begin
                cmd_valid          = 1'b1;
                cmd                = {1'b0, d1, 1'b0, i_byte[6:0]};
                cmd[CMD_START_BIT] = 1'b1;
              end else if ((hi == NOTE_ON || hi == NOTE_OFF) && d1 != STOP_ALL_NOTE) begin
                cmd_valid = 1'b1;
                cmd       = {1'b0, d1, 8'h00};
              end else if (hi == CC && (d1 == CC_ALL_SOUND_OFF || d1 == CC_ALL_NOTES_OFF)) begin
                cmd_valid = 1'b1;
                cmd       = STOP_ALL_CMD;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      status <= '0;
    end else begin
      state <= next_state;
      if (status_load) status <= i_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (d1_load) d1 <= i_byte[6:0];
  end

  cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cmd_valid),
    .push_data (cmd),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
  );

  assign pop = !empty && (gap_cnt == '0);

  // Output register: one-cycle command, then GAP_CYCLES forced idle cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      o_valid <= pop;
      o_data  <= pop ? pop_data : 16'h0000;
      if (pop)                gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      if (cmd_valid && full && !pop) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_midi_cmd_decoder.sv
// Bench: message-level reference model with per-cycle compare, directed scenarios and random bytes.
module tb_midi_cmd_decoder;

  localparam int DEPTH = 4;
  localparam int GAP   = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        i_byte_valid = 1'b0;
  logic [3:0]  i_channel = 4'h0;
  logic        i_omni = 1'b1;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_overflow;

  midi_cmd_decoder #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .i_channel    (i_channel),
    .i_omni       (i_omni),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; logic [15:0] d; } ev_t;

  int          cyc = 0;
  logic [15:0] mq[$];
  ev_t         mlog[$];
  int          next_ok = 0;
  bit          m_sysex = 0;
  int          m_rs = -1;
  logic [7:0]  mdq[$];
  bit          exp_valid = 0;
  logic [15:0] exp_data = 0;
  bit          exp_ovf = 0;

  function automatic void model_reset();
    mq.delete();
    mdq.delete();
    next_ok   = 0;
    m_sysex   = 0;
    m_rs      = -1;
    exp_valid = 0;
    exp_data  = 0;
    exp_ovf   = 0;
  endfunction

  // Returns {produced, command} for one received byte.
  function automatic logic [16:0] model_byte(logic [7:0] b, bit omni, logic [3:0] ch);
    logic [7:0] d1, v;
    int hi;
    if (b >= 8'hF8) return 17'd0;
    if (m_sysex && !(b >= 8'h80 && b <= 8'hEF)) begin
      if (b == 8'hF7) m_sysex = 0;
      return 17'd0;
    end
    m_sysex = 0;
    if (b == 8'hF0) begin m_sysex = 1; m_rs = -1; mdq.delete(); return 17'd0; end
    if (b >= 8'hF1) begin m_rs = -1; mdq.delete(); return 17'd0; end
    if (b >= 8'h80) begin m_rs = b; mdq.delete(); return 17'd0; end
    if (m_rs < 0) return 17'd0;
    mdq.push_back(b);
    hi = m_rs / 16;
    if (hi == 12 || hi == 13) begin mdq.delete(); return 17'd0; end
    if (mdq.size() < 2) return 17'd0;
    d1 = mdq[0];
    v  = mdq[1];
    mdq.delete();
    if (!(omni || (m_rs % 16) == int'(ch))) return 17'd0;
    if (hi == 9 && v != 0) return {1'b1, 1'b1, d1[6:0], v};
    if ((hi == 9 || hi == 8) && d1 != 8'h7F) return {1'b1, 1'b0, d1[6:0], 8'h00};
    if (hi == 11 && (d1 == 8'h78 || d1 == 8'h7B)) return {1'b1, 16'h7F00};
    return 17'd0;
  endfunction

  always @(posedge clk) begin
    logic [16:0] r;
    cyc++;
    if (!reset_n) begin
      model_reset();
    end else begin
      if (mq.size() > 0 && cyc >= next_ok) begin
        exp_data  = mq.pop_front();
        exp_valid = 1;
        next_ok   = cyc + GAP + 1;
        mlog.push_back('{cyc, exp_data});
      end else begin
        exp_valid = 0;
        exp_data  = 0;
      end
      if (i_byte_valid) begin
        r = model_byte(i_byte, i_omni, i_channel);
        if (r[16]) begin
          if (mq.size() < DEPTH) mq.push_back(r[15:0]);
          else exp_ovf = 1;
        end
      end
    end
    #1;
    chk("o_data", {16'd0, o_data}, {16'd0, exp_data});
    chk("o_valid", {31'd0, o_valid}, {31'd0, exp_valid});
    chk("o_overflow", {31'd0, o_overflow}, {31'd0, exp_ovf});
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] md(int i);
    return (mlog.size() > i) ? mlog[i].d : 16'hDEAD;
  endfunction

  function automatic int mc(int i);
    return (mlog.size() > i) ? mlog[i].cyc : -1000;
  endfunction

  task automatic put(logic [7:0] b);
    i_byte       = b;
    i_byte_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    i_byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    i_byte_valid = 1'b0;
    reset_n      = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [3:0] his [8];
    his = '{4'h8, 4'h9, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hA};
    r = $urandom_range(0, 99);
    if (r < 12) return {his[$urandom_range(0, 7)], 4'($urandom_range(0, 2))};
    if (r < 15) return 8'($urandom_range(8'hF8, 8'hFF));
    if (r < 17) return 8'hF0;
    if (r < 19) return 8'hF7;
    if (r < 20) return 8'($urandom_range(8'hF1, 8'hF6));
    case ($urandom_range(0, 5))
      0: return 8'h78;
      1: return 8'h7B;
      2: return 8'h7F;
      3: return 8'h00;
      default: return 8'($urandom_range(0, 127));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int e;
    int waited;
    repeat (3) @(negedge clk);
    chk("reset_data", {16'd0, o_data}, 32'd0);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_ovf", {31'd0, o_overflow}, 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Single note-on, latency and one-cycle pulse
    mlog.delete();
    put(8'h90); put(8'h45); put(8'h40);
    e = cyc;
    idle(20);
    chk("t1_count", mlog.size(), 1);
    chk("t1_data", {16'd0, md(0)}, 32'h0000_C540);
    chk("t1_latency", mc(0), e + 1);

    // Running status, velocity-0 stop, note 127 stop dropped
    mlog.delete();
    put(8'h90); put(8'h45); put(8'h40); put(8'h45); put(8'h00);
    idle(2);
    put(8'h80); put(8'h7F); put(8'h10);
    idle(20);
    chk("t2_count", mlog.size(), 2);
    chk("t2_start", {16'd0, md(0)}, 32'h0000_C540);
    chk("t2_stop", {16'd0, md(1)}, 32'h0000_4500);

    // Channel filter and STOP_ALL
    mlog.delete();
    i_omni = 1'b0; i_channel = 4'h1;
    put(8'h90); put(8'h3C); put(8'h20);
    put(8'h91); put(8'h3C); put(8'h20);
    put(8'hB1); put(8'h7B); put(8'h00);
    idle(20);
    chk("t3_count", mlog.size(), 2);
    chk("t3_note", {16'd0, md(0)}, 32'h0000_BC20);
    chk("t3_stopall", {16'd0, md(1)}, 32'h0000_7F00);
    i_omni = 1'b1; i_channel = 4'h0;

    // Realtime and sysex interleaving, program change
    mlog.delete();
    put(8'h90); put(8'hF8); put(8'h28); put(8'hF0); put(8'h01); put(8'h02); put(8'hF7);
    idle(20);
    chk("t4_sysex_none", mlog.size(), 0);
    put(8'h90); put(8'h28); put(8'h7F);
    put(8'hC0); put(8'h05); put(8'h90); put(8'h28); put(8'h10);
    idle(20);
    chk("t4_count", mlog.size(), 2);
    chk("t4_a", {16'd0, md(0)}, 32'h0000_A87F);
    chk("t4_b", {16'd0, md(1)}, 32'h0000_A810);

    // Pacing, full-with-pop acceptance, overflow
    pulse_reset();
    idle(2);
    mlog.delete();
    put(8'h90);
    for (int k = 0; k < 8; k++) begin put(8'h30 + 8'(k)); put(8'h40); end
    idle(1);
    put(8'h38); put(8'h40);
    chk("t5_no_ovf_fullpop", {31'd0, o_overflow}, 32'd0);
    put(8'h39); put(8'h40);
    put(8'h3A); put(8'h40);
    chk("t5_ovf", {31'd0, o_overflow}, 32'd1);
    chk("t5_first", {16'd0, md(0)}, 32'h0000_B040);
    chk("t5_spacing", mc(1) - mc(0), GAP + 1);
    i_byte_valid = 1'b0;
    waited = 0;
    while (o_valid !== 1'b1 && waited < 12) begin @(negedge clk); waited++; end
    chk("t5_valid_seen", {31'd0, o_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_data", {16'd0, o_data}, 32'd0);
    chk("t5_rst_valid", {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mlog.delete();
    idle(20);
    chk("t5_after_rst", mlog.size(), 0);
    chk("t5_ovf_cleared", {31'd0, o_overflow}, 32'd0);

    // Reset clears running status
    mlog.delete();
    put(8'h90);
    pulse_reset();
    put(8'h45); put(8'h40);
    idle(20);
    chk("t6_none", mlog.size(), 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        pulse_reset();
      end else begin
        if ($urandom_range(0, 99) < 3) begin
          i_omni    = 1'($urandom_range(0, 1));
          i_channel = 4'($urandom_range(0, 2));
        end
        if ($urandom_range(0, 99) < 60) put(rand_byte());
        else idle(1);
      end
    end
    idle(30);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
